// File: rtl/ram16k_arbiter_if.sv
// Requester-side bus for the RAM arbiter: CPU and DMA request/grant/read-return.
// The arbiter takes the slave modport; requesters (or a bench) drive the master side.
interface ram16k_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata
    );
endinterface

// File: rtl/ram16k_arbiter.sv
// Primary-port controller for the 16K x 16 data RAM: quantum-limited round-robin
// between CPU and DMA, plus a bulk-clear engine that overwrites every word.
module ram16k_arbiter #(
    parameter int              ADDR_W      = 14,
    parameter int              DATA_W      = 16,
    parameter int              QUANTUM     = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    ram16k_arbiter_if.slave   bus,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in_value,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);
    localparam int              RC_W = $clog2(QUANTUM + 1);
    localparam logic [RC_W-1:0] QMAX = RC_W'(QUANTUM);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t            state, state_nxt;
    logic              owner;      // 0 = CPU, 1 = DMA
    logic [RC_W-1:0]   run_count;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_pend_cpu, rd_pend_dma;

    logic own_req, oth_req, win_vld, win, win_we, arb_en, accept;

    // Winner selection: the owner keeps the port until its quantum runs out,
    // but only yields if the other side is actually asking.
    always_comb begin
        own_req = owner ? bus.dma_req : bus.cpu_req;
        oth_req = owner ? bus.cpu_req : bus.dma_req;
        win_vld = 1'b0;
        win     = owner;
        if (own_req && run_count < QMAX) begin
            win_vld = 1'b1;
        end else if (oth_req) begin
            win_vld = 1'b1;
            win     = ~owner;
        end else if (own_req) begin
            win_vld = 1'b1;
        end
    end

    assign arb_en      = reset_n && (state == ARB) && !clear_start;
    assign accept      = arb_en && win_vld;
    assign win_we      = win ? bus.dma_we : bus.cpu_we;
    assign bus.cpu_gnt = accept && !win;
    assign bus.dma_gnt = accept && win;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ARB;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ram_address  = win_vld && win ? bus.dma_addr  : bus.cpu_addr;
        ram_in_value = win_vld && win ? bus.dma_wdata : bus.cpu_wdata;
        ram_load     = accept && win_we;
        case (state)
            ARB: begin
                if (clear_start) state_nxt = CLEAR;
            end
            CLEAR: begin
                ram_address  = clr_addr;
                ram_in_value = CLEAR_VALUE;
                ram_load     = reset_n;   // an aborting reset must not write
                if (clr_addr == '1) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner       <= 1'b0;
            run_count   <= '0;
            clr_addr    <= '0;
            rd_pend_cpu <= 1'b0;
            rd_pend_dma <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            rd_pend_cpu <= accept && !win && !bus.cpu_we;
            rd_pend_dma <= accept &&  win && !bus.dma_we;
            clear_done  <= (state == CLEAR) && (state_nxt == ARB);
            if (state == ARB && clear_start) begin
                owner     <= 1'b0;
                run_count <= '0;
                clr_addr  <= '0;
            end else if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end else if (accept) begin
                if (win == owner) begin
                    if (run_count < QMAX) run_count <= run_count + RC_W'(1);
                end else begin
                    owner     <= win;
                    run_count <= RC_W'(1);
                end
            end else begin
                run_count <= '0;
            end
        end
    end

    assign clear_busy     = (state == CLEAR);
    assign bus.cpu_rvalid = rd_pend_cpu;
    assign bus.dma_rvalid = rd_pend_dma;
    assign bus.cpu_rdata  = rd_pend_cpu ? ram_out : '0;
    assign bus.dma_rdata  = rd_pend_dma ? ram_out : '0;
endmodule

// File: tb/tb_ram16k_arbiter.sv
// Scoreboard bench for ram16k_arbiter: behavioural RAM, directed accesses, clear and reset cases.
module tb_ram16k_arbiter;
    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done, ram_load;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_in_value, ram_out;

    always #5 clk = ~clk;

    ram16k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    ram16k_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .ram_address  (ram_address),
        .ram_in_value (ram_in_value),
        .ram_load     (ram_load),
        .ram_out      (ram_out)
    );

    // Registered-read RAM with one cycle of latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in_value;
        ram_out <= mem[ram_address];
    end

    int            n_chk = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] exp_cpu[$];
    logic [DW-1:0] exp_dma[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-return monitor: every rvalid must match the oldest outstanding read of that side
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.cpu_rvalid === 1'b1) begin
                if (exp_cpu.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
                else                     chk("cpu_rdata", bus.cpu_rdata, exp_cpu.pop_front());
            end else begin
                chk("cpu_rdata_idle", {bus.cpu_rvalid, bus.cpu_rdata}, 0);
            end
            if (bus.dma_rvalid === 1'b1) begin
                if (exp_dma.size() == 0) chk("dma_rvalid_unexpected", 1, 0);
                else                     chk("dma_rdata", bus.dma_rdata, exp_dma.pop_front());
            end else begin
                chk("dma_rdata_idle", {bus.dma_rvalid, bus.dma_rdata}, 0);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge
    task automatic access(input bit side, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp);
        bit got = 1'b0;
        if (!side) begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end else begin
            bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = side ? bus.dma_gnt : bus.cpu_gnt;
        end
        chk(side ? "dma_access_gnt" : "cpu_access_gnt", {31'd0, got}, 1);
        if (got && !we) begin
            if (side) exp_dma.push_back(exp);
            else      exp_cpu.push_back(exp);
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  busy_cnt, done_cnt, gnt_busy, load_gap;
        bit  exp_c;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h5A5A;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = 16'h1111;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = '0; bus.dma_wdata = 16'h2222;

        // Reset: requests present but nothing is granted or written
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_dma_gnt", bus.dma_gnt, 0);
        chk("rst_ram_load", ram_load, 0);
        chk("rst_busy_done", {clear_busy, clear_done}, 0);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        reset_n = 1'b1;

        // Basic write then read on consecutive edges
        access(1, 1, 14'd5, 16'h1234, 16'h0);
        access(0, 0, 14'd5, 16'h0, 16'h1234);
        access(0, 1, 14'd6, 16'hABCD, 16'h0);
        repeat (2) @(posedge clk); #1;

        // Contention from a clean reset: CPU x4, DMA x4, CPU x4
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd5;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 14'd6;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_c = (k < 4) || (k >= 8);
            chk("cont_cpu_gnt", bus.cpu_gnt, exp_c);
            chk("cont_dma_gnt", bus.dma_gnt, !exp_c);
            chk("cont_ram_load", ram_load, 0);
            if (exp_c) exp_cpu.push_back(16'h1234);
            else       exp_dma.push_back(16'hABCD);
            @(posedge clk); #1;
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Lone DMA requester: granted every cycle past the quantum
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 14'd6;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("lone_dma_gnt", bus.dma_gnt, 1);
            chk("lone_cpu_gnt", bus.cpu_gnt, 0);
            exp_dma.push_back(16'hABCD);
            @(posedge clk); #1;
        end
        bus.dma_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Full clear, started together with both requesters asking
        access(0, 1, 14'd0,     16'hBEEF, 16'h0);
        access(0, 1, 14'd16383, 16'hBEEF, 16'h0);
        access(0, 0, 14'd0,     16'h0,    16'hBEEF);
        access(1, 0, 14'd16383, 16'h0,    16'hBEEF);
        clear_start = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 14'd7; bus.dma_wdata = 16'h7777;
        @(negedge clk);
        chk("start_cpu_gnt", bus.cpu_gnt, 0);
        chk("start_dma_gnt", bus.dma_gnt, 0);
        chk("start_ram_load", ram_load, 0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        bus.dma_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; gnt_busy = 0; load_gap = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!clear_busy) break;
            busy_cnt++;
            done_cnt += int'(clear_done);
            if (bus.cpu_gnt || bus.dma_gnt) gnt_busy++;
            if (!ram_load) load_gap++;
            if (i == 10) clear_start = 1'b1;   // ignored while clearing
            if (i == 11) clear_start = 1'b0;
        end
        chk("clear_busy_cycles", busy_cnt, DEPTH);
        chk("clear_done_early", done_cnt, 0);
        chk("clear_gnt_while_busy", gnt_busy, 0);
        chk("clear_load_gaps", load_gap, 0);
        chk("clear_done_pulse", clear_done, 1);
        // First ARB cycle after the clear: the held CPU read is granted
        chk("clear_cpu_first_gnt", bus.cpu_gnt, 1);
        exp_cpu.push_back(16'h0000);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("clear_done_one_cycle", {clear_busy, clear_done}, 0);
        @(posedge clk); #1;
        access(0, 0, 14'd16383, 16'h0, 16'h0000);
        access(1, 0, 14'd7,     16'h0, 16'h0000);

        // Reset during busy cycle 100 (which would write address 99)
        access(0, 1, 14'd50,  16'hBEEF, 16'h0);
        access(0, 1, 14'd98,  16'hBEEF, 16'h0);
        access(0, 1, 14'd99,  16'hBEEF, 16'h0);
        access(0, 1, 14'd200, 16'hBEEF, 16'h0);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 500 && busy_cnt < 100; i++) begin
            @(negedge clk);
            if (clear_busy) busy_cnt++;
        end
        chk("abort_reach_cycle", busy_cnt, 100);
        #1 reset_n = 1'b0;
        #1 chk("abort_ram_load", ram_load, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk("abort_busy", clear_busy, 0);
            done_cnt += int'(clear_done);
        end
        chk("abort_no_done", done_cnt, 0);
        @(posedge clk); #1;
        access(0, 0, 14'd50,  16'h0, 16'h0000);
        access(0, 0, 14'd98,  16'h0, 16'h0000);
        access(1, 0, 14'd99,  16'h0, 16'hBEEF);
        access(0, 0, 14'd200, 16'h0, 16'hBEEF);
        repeat (3) @(posedge clk);

        chk("cpu_reads_outstanding", exp_cpu.size(), 0);
        chk("dma_reads_outstanding", exp_dma.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
